aes_iterative_encryptor: RTL and testbench



---
 rtl/aes_iterative_encryptor.sv | 241 ++++++++++++++++++++++++
 tb/tb_aes_iterative_encryptor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iterative_encryptor.sv
// aes_iterative_encryptor: iterative AES-128 encryption engine.
// One plaintext/key pair is accepted per input handshake. ROUNDS_PER_CYCLE unrolled
// rounds (each with on-the-fly key expansion) are applied per clock. The ciphertext
// is held on a registered valid/ready output until it is taken.
// Byte i of a block sits in bits [8i+7:8i]; column c holds bytes 4c..4c+3.
module aes_iterative_encryptor #(
    parameter int unsigned ROUNDS_PER_CYCLE    = 1,
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             data_in_valid,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] data_in,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] key_in,
    output logic                             data_in_ready,
    output logic                             data_out_valid,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] data_out,
    input  logic                             data_out_ready,
    output logic                             busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rounds
        $error("aes_iterative_encryptor: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    if (DATA_WIDTH_IN_BYTES != 16) begin : g_bad_width
        $error("aes_iterative_encryptor: DATA_WIDTH_IN_BYTES must be 16");
    end

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) begin
            o[8*i +: 8] = SBOX[w[8*i +: 8]];
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] o;
        case (rnd)
            4'd1:    o = 8'h01;
            4'd2:    o = 8'h02;
            4'd3:    o = 8'h04;
            4'd4:    o = 8'h08;
            4'd5:    o = 8'h10;
            4'd6:    o = 8'h20;
            4'd7:    o = 8'h40;
            4'd8:    o = 8'h80;
            4'd9:    o = 8'h1b;
            4'd10:   o = 8'h36;
            default: o = 8'h00;
        endcase
        return o;
    endfunction

    // Derive round key rnd from round key rnd-1.
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0]  t;
        logic [127:0] o;
        // RotWord moves byte 1 of word 3 into byte 0.
        t          = sub_word({k[103:96], k[127:104]}) ^ {24'h0, rcon(rnd)};
        o[31:0]    = k[31:0] ^ t;
        o[63:32]   = k[63:32] ^ o[31:0];
        o[95:64]   = k[95:64] ^ o[63:32];
        o[127:96]  = k[127:96] ^ o[95:64];
        return o;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // Row r of the output column c comes from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)   +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            o[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Full cipher round; the final round skips MixColumns.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        if (!last) begin
            t = mix_columns(t);
        end
        return t ^ rk;
    endfunction

    fsm_e         r_fsm;
    fsm_e         w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_cnt;
    logic [127:0] r_dout;

    logic [127:0] w_round_state;
    logic [127:0] w_round_key;
    logic [3:0]   w_cnt_next;
    logic         w_final;

    assign w_cnt_next = r_cnt + 4'(ROUNDS_PER_CYCLE);
    assign w_final    = (w_cnt_next == 4'd10);

    // Unrolled rounds applied this clock to the registered state and round key.
    always_comb begin
        logic [127:0] v_state;
        logic [127:0] v_key;
        logic [3:0]   v_rnd;
        v_state = r_state;
        v_key   = r_key;
        v_rnd   = r_cnt;
        for (int j = 0; j < int'(ROUNDS_PER_CYCLE); j++) begin
            v_rnd   = v_rnd + 4'd1;
            v_key   = next_key(v_key, v_rnd);
            v_state = enc_round(v_state, v_key, v_rnd == 4'd10);
        end
        w_round_state = v_state;
        w_round_key   = v_key;
    end

    // Next-state decode for the IDLE/BUSY/DONE control FSM.
    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            StIdle:  if (data_in_valid)  w_fsm_next = StBusy;
            StBusy:  if (w_final)        w_fsm_next = StDone;
            StDone:  if (data_out_ready) w_fsm_next = StIdle;
            default: w_fsm_next = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= StIdle;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Datapath: load on accept, iterate while busy, capture the ciphertext on the last pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else if (r_fsm == StIdle && data_in_valid) begin
            r_state <= data_in ^ key_in;
            r_key   <= key_in;
            r_cnt   <= '0;
        end else if (r_fsm == StBusy) begin
            r_state <= w_round_state;
            r_key   <= w_round_key;
            r_cnt   <= w_cnt_next;
            if (w_final) begin
                r_dout <= w_round_state;
            end
        end
    end

    // Ready is forced low while reset is applied.
    assign data_in_ready  = (r_fsm == StIdle) && rst_n;
    assign data_out_valid = (r_fsm == StDone);
    assign busy           = (r_fsm == StBusy);
    assign data_out       = r_dout;

endmodule

// File: tb/tb_aes_iterative_encryptor.sv
// Bench for aes_iterative_encryptor: known-answer vectors for every legal unroll factor,
// backpressure, back-to-back throughput, mid-operation reset and random handshake stress.
// Expected ciphertexts come from an independent byte-array AES model whose S-box is
// computed from the GF(2^8) inverse.
module tb_aes_iterative_encryptor;

    localparam int unsigned R = 1;
    localparam int unsigned N = 10 / R;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         data_in_valid;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         data_in_ready;
    logic         data_out_valid;
    logic [127:0] data_out;
    logic         data_out_ready;
    logic         busy;

    // Extra instances for ROUNDS_PER_CYCLE = 2, 5, 10.
    logic         x_in_valid  [3];
    logic         x_in_ready  [3];
    logic         x_out_valid [3];
    logic [127:0] x_out       [3];
    logic         x_out_ready [3];
    logic         x_busy      [3];

    always #5 clk = ~clk;

    aes_iterative_encryptor #(
        .ROUNDS_PER_CYCLE   (R),
        .DATA_WIDTH_IN_BYTES(16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .key_in        (key_in),
        .data_in_ready (data_in_ready),
        .data_out_valid(data_out_valid),
        .data_out      (data_out),
        .data_out_ready(data_out_ready),
        .busy          (busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_extra
        aes_iterative_encryptor #(
            .ROUNDS_PER_CYCLE   ((g == 0) ? 2 : (g == 1) ? 5 : 10),
            .DATA_WIDTH_IN_BYTES(16)
        ) u_dut_x (
            .clk           (clk),
            .rst_n         (rst_n),
            .data_in_valid (x_in_valid[g]),
            .data_in       (data_in),
            .key_in        (key_in),
            .data_in_ready (x_in_ready[g]),
            .data_out_valid(x_out_valid[g]),
            .data_out      (x_out[g]),
            .data_out_ready(x_out_ready[g]),
            .busy          (x_busy[g])
        );
    end

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           accepts = 0;
    int           outputs = 0;
    logic [127:0] exp_q [$];
    logic         stall_prev = 1'b0;
    logic [127:0] dout_prev = '0;
    logic [7:0]   sb [256];
    logic [7:0]   rc [11];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Convert a FIPS-197 hex string (byte 0 leftmost) to the port packing.
    function automatic logic [127:0] fips(input logic [127:0] x);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = x[8*(15-i) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[7:0], tmp[31:8]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp[7:0] = tmp[7:0] ^ rc[i/4];
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ key[8*i +: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'd2) ^ gmul(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'd2) ^ gmul(t[4*c+2], 8'd3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'd2) ^ gmul(t[4*c+3], 8'd3);
                    s[4*c+3] = gmul(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'd2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][8*r +: 8];
            end
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    // One clock of the main DUT: scoreboard bookkeeping for the coming edge, then advance.
    task automatic tick();
        if (stall_prev) check("hold_stable", data_out, dout_prev);
        if (data_in_valid && data_in_ready) begin
            exp_q.push_back(ref_enc(data_in, key_in));
            accepts++;
        end
        if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 128'(exp_q.size()), 128'd1);
            else check("scoreboard", data_out, exp_q.pop_front());
            outputs++;
        end
        stall_prev = data_out_valid && !data_out_ready && rst_n;
        dout_prev  = data_out;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Known-answer run on the main DUT; valid appears in the (N+1)th cycle after accept.
    task automatic run_kat(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] ct);
        int lat;
        int nbusy;
        data_in        = pt;
        key_in         = key;
        data_out_ready = 1'b0;
        check({tag, "_ready"}, 128'(data_in_ready), 128'd1);
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        check({tag, "_ready_busy"}, 128'(data_in_ready), 128'd0);
        lat   = 1;
        nbusy = 0;
        while (!data_out_valid && lat < int'(4*N + 8)) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(N + 1));
        check({tag, "_busy_cycles"}, 128'(nbusy), 128'(N));
        check({tag, "_ct"}, data_out, ct);
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        check({tag, "_idle"}, 128'({data_in_ready, data_out_valid, busy}), 128'(3'b100));
    endtask

    initial begin : main
        logic [127:0] kc1, pc1, cc1, kb, pb, cb, snap;
        logic [127:0] vk, vp, vc;
        int           lat, nk, n, guard, prev_acc, acc0, out0, cnt;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int i = 2; i < 11; i++) rc[i] = gmul(rc[i-1], 8'h02);

        kc1 = fips(128'h000102030405060708090a0b0c0d0e0f);
        pc1 = fips(128'h00112233445566778899aabbccddeeff);
        cc1 = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        kb  = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        pb  = fips(128'h3243f6a8885a308d313198a2e0370734);
        cb  = fips(128'h3925841d02dc09fbdc118597196a0b32);

        rst_n          = 1'b0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        key_in         = '0;
        data_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            x_in_valid[k]  = 1'b0;
            x_out_ready[k] = 1'b0;
        end

        // Reset state.
        @(negedge clk);
        check("rst_ready_low", 128'(data_in_ready), 128'd0);
        tick();
        tick();
        check("rst_outputs", 128'({data_in_ready, data_out_valid, busy}), 128'd0);
        check("rst_dout", data_out, 128'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 128'(data_in_ready), 128'd1);

        // Known-answer vectors on R=1.
        run_kat("c1", pc1, kc1, cc1);
        run_kat("appb", pb, kb, cb);

        // Known-answer vectors on R=2, 5, 10.
        for (int k = 0; k < 3; k++) begin
            nk = 10 / ((k == 0) ? 2 : (k == 1) ? 5 : 10);
            for (int v = 0; v < 2; v++) begin
                vp = (v == 0) ? pc1 : pb;
                vk = (v == 0) ? kc1 : kb;
                vc = (v == 0) ? cc1 : cb;
                data_in = vp;
                key_in  = vk;
                check($sformatf("x%0d_v%0d_ready", k, v), 128'(x_in_ready[k]), 128'd1);
                x_in_valid[k] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                x_in_valid[k] = 1'b0;
                lat = 1;
                while (!x_out_valid[k] && lat < 30) begin
                    @(posedge clk);
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("x%0d_v%0d_latency", k, v), 128'(lat), 128'(nk + 1));
                check($sformatf("x%0d_v%0d_ct", k, v), x_out[k], vc);
                x_out_ready[k] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                x_out_ready[k] = 1'b0;
                check($sformatf("x%0d_v%0d_idle", k, v),
                      128'({x_in_ready[k], x_out_valid[k], x_busy[k]}), 128'(3'b100));
            end
        end

        // Backpressure: stall 20 cycles in DONE while offering new blocks.
        data_in       = rand128();
        key_in        = rand128();
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        guard = 0;
        while (!data_out_valid && guard < int'(4*N + 8)) begin
            tick();
            guard++;
        end
        check("bp_valid_seen", 128'(data_out_valid), 128'd1);
        snap = data_out;
        acc0 = accepts;
        out0 = outputs;
        for (int i = 0; i < 20; i++) begin
            data_in       = rand128();
            key_in        = rand128();
            data_in_valid = 1'b1;
            check("bp_in_ready", 128'(data_in_ready), 128'd0);
            check("bp_out_valid", 128'(data_out_valid), 128'd1);
            tick();
        end
        check("bp_dout", data_out, snap);
        check("bp_no_accept", 128'(accepts), 128'(acc0));
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        check("bp_one_output", 128'(outputs), 128'(out0 + 1));
        check("bp_idle", 128'({data_in_ready, data_out_valid, busy}), 128'(3'b100));
        check("bp_queue_empty", 128'(exp_q.size()), 128'd0);

        // Back-to-back: 100 random blocks with the output always accepted.
        data_out_ready = 1'b1;
        prev_acc       = -1;
        n              = 0;
        guard          = 0;
        while (n < 100 && guard < int'(100 * (N + 2) + 50)) begin
            data_in       = rand128();
            key_in        = rand128();
            data_in_valid = 1'b1;
            if (data_in_ready) begin
                if (prev_acc >= 0) check("b2b_period", 128'(cyc - prev_acc), 128'(N + 2));
                prev_acc = cyc;
                n++;
            end
            tick();
            guard++;
        end
        data_in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < int'(4*N + 8)) begin
            tick();
            guard++;
        end
        check("b2b_count", 128'(n), 128'd100);
        check("b2b_drained", 128'(exp_q.size()), 128'd0);
        data_out_ready = 1'b0;

        // Reset on the third BUSY cycle discards the block.
        data_in       = pc1;
        key_in        = kc1;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready_low", 128'(data_in_ready), 128'd0);
        tick();
        check("mid_rst_outputs", 128'({busy, data_out_valid}), 128'd0);
        check("mid_rst_dout", data_out, 128'd0);
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 128'(data_in_ready), 128'd1);
        out0 = outputs;
        data_out_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        data_out_ready = 1'b0;
        check("mid_rst_no_output", 128'(outputs), 128'(out0));
        run_kat("c1_after_rst", pc1, kc1, cc1);

        // Random valid/ready stress.
        acc0 = accepts;
        out0 = outputs;
        for (int i = 0; i < 10000; i++) begin
            data_in_valid  = 1'($urandom_range(0, 1));
            data_out_ready = 1'($urandom_range(0, 1));
            data_in        = rand128();
            key_in         = rand128();
            tick();
        end
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < int'(4*N + 8)) begin
            tick();
            guard++;
        end
        cnt = accepts - acc0;
        check("stress_drained", 128'(exp_q.size()), 128'd0);
        check("stress_in_out", 128'(outputs - out0), 128'(cnt));
        check("stress_final_idle", 128'({data_in_ready, data_out_valid, busy}), 128'(3'b100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
